exhaustive_checker: RTL and testbench

- Synthesizable, parametrised exhaustive-vector self-check engine.
- Drives every N_IN-bit input combination, in ascending order, to a reference model and a device under test. Waits a programmable settle time, then compares the two outputs.
- Counts mismatches and captures the first failing vector.
- Replaces hand-written count-and-strobe benches for small combinational gates (AO/OA/AOI families) and runs in simulation or on the lab board.

---
 rtl/exhaustive_checker.sv | 123 ++++++++++++
 tb/tb_exhaustive_checker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_checker.sv
// Exhaustive-vector self-check engine: walks every N_IN-bit vector in ascending
// order, lets it settle, then compares a reference output against a DUT output.
module exhaustive_checker #(
  parameter int N_IN   = 5,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 3,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop_on_err,
  output logic [N_IN-1:0]  vec,
  input  logic [N_OUT-1:0] z_ref,
  input  logic [N_OUT-1:0] z_dut,
  output logic             busy,
  output logic             cmp_strobe,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [N_IN-1:0]  first_err_vec
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             stop_q, nxt_stop;
  logic [N_IN-1:0]  nxt_vec, nxt_fvec;
  logic [ERR_W-1:0] nxt_err;
  logic             nxt_fvalid;
  logic             mismatch;

  // z_ref/z_dut only feed next-state logic, so every output stays registered.
  assign mismatch = |(z_ref ^ z_dut);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_stop   = stop_q;
    nxt_vec    = vec;
    nxt_err    = err_cnt;
    nxt_fvalid = first_err_valid;
    nxt_fvec   = first_err_vec;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          nxt_state  = ST_SETTLE;
          nxt_cnt    = '0;
          nxt_stop   = stop_on_err;
          nxt_vec    = '0;
          nxt_err    = '0;
          nxt_fvalid = 1'b0;
          nxt_fvec   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt == CNT_LAST) nxt_state = ST_CHECK;
        else                 nxt_cnt   = cnt + CNT_W'(1);
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (!(&err_cnt)) nxt_err = err_cnt + ERR_W'(1);
          if (!first_err_valid) begin
            nxt_fvalid = 1'b1;
            nxt_fvec   = vec;
          end
        end
        // Termination is decided on all-ones before incrementing, so vec never wraps.
        if ((&vec) || (stop_q && mismatch)) begin
          nxt_state = ST_DONE;
        end else begin
          nxt_state = ST_SETTLE;
          nxt_vec   = vec + N_IN'(1);
          nxt_cnt   = '0;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      stop_q          <= 1'b0;
      vec             <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      busy            <= 1'b0;
      cmp_strobe      <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else begin
      cnt             <= nxt_cnt;
      stop_q          <= nxt_stop;
      vec             <= nxt_vec;
      err_cnt         <= nxt_err;
      first_err_valid <= nxt_fvalid;
      first_err_vec   <= nxt_fvec;
      busy            <= (nxt_state == ST_SETTLE) || (nxt_state == ST_CHECK);
      cmp_strobe      <= (nxt_state == ST_CHECK);
      done            <= (nxt_state == ST_DONE);
      pass            <= (nxt_state == ST_DONE) && (nxt_err == '0);
    end
  end

endmodule

// File: tb/tb_exhaustive_checker.sv
// Directed bench for exhaustive_checker: timing, injection, stop-on-error,
// saturation, async reset and start handling.
module tb_exhaustive_checker;

  localparam int N_IN   = 5;
  localparam int N_OUT  = 1;
  localparam int SETTLE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, stop_on_err;
  logic inj_en, inj3_en;
  logic [N_IN-1:0]  vec, first_err_vec;
  logic [N_OUT-1:0] z_ref, z_dut;
  logic busy, cmp_strobe, done, pass, first_err_valid;
  logic [7:0] err_cnt;

  logic start_s;
  logic [N_IN-1:0]  vec_s, first_err_vec_s;
  logic [N_OUT-1:0] z_ref_s, z_dut_s;
  logic busy_s, cmp_strobe_s, done_s, pass_s, first_err_valid_s;
  logic [1:0] err_cnt_s;

  int compared   = 0;
  int mismatched = 0;
  int cycles, pat_errs;
  logic snap_done, snap_pass, snap_fv;
  logic [7:0] snap_err;

  // AOI-style gate used as the reference function.
  function automatic logic ref_fn(input logic [4:0] v);
    return ~((v[0] & v[1]) | (v[2] & v[3]) | v[4]);
  endfunction

  assign z_ref   = ref_fn(vec);
  assign z_dut   = z_ref ^ ((inj_en && (vec == 5'd13 || vec == 5'd20)) ||
                            (inj3_en && vec == 5'd3));
  assign z_ref_s = ref_fn(vec_s);
  assign z_dut_s = ~z_ref_s;

  exhaustive_checker #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(SETTLE), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop_on_err(stop_on_err),
    .vec(vec), .z_ref(z_ref), .z_dut(z_dut), .busy(busy), .cmp_strobe(cmp_strobe),
    .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
  );

  exhaustive_checker #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(SETTLE), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .stop_on_err(1'b0),
    .vec(vec_s), .z_ref(z_ref_s), .z_dut(z_dut_s), .busy(busy_s), .cmp_strobe(cmp_strobe_s),
    .done(done_s), .pass(pass_s), .err_cnt(err_cnt_s),
    .first_err_valid(first_err_valid_s), .first_err_vec(first_err_vec_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start, snapshots flags right after the start edge, then counts
  // cycles to done while checking the strobe/vec cadence.
  task automatic do_run(input logic stop, input int ignore_at,
                        output int n_cyc, output int n_pat);
    @(negedge clk);
    stop_on_err = stop;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop_on_err = 1'b0;
    snap_done = done; snap_pass = pass; snap_err = err_cnt; snap_fv = first_err_valid;
    n_cyc = 0;
    n_pat = 0;
    while (!done && n_cyc < 400) begin
      @(posedge clk); #1;
      n_cyc++;
      start = 1'b0;
      if (!done) begin
        if (cmp_strobe !== ((n_cyc % 4) == 3)) n_pat++;
        if (cmp_strobe && vec !== N_IN'(n_cyc / 4)) n_pat++;
        if (busy !== 1'b1) n_pat++;
      end
      if (n_cyc == ignore_at) start = 1'b1;
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop_on_err = 1'b0; start_s = 1'b0;
    inj_en = 1'b0; inj3_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vec", vec, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_busy", busy, 0);
    check("rst_strobe", cmp_strobe, 0);
    check("rst_fvalid", first_err_valid, 0);
    check("rst_fvec", first_err_vec, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);

    // Clean run: 32 vectors x 4 cycles.
    do_run(1'b0, -1, cycles, pat_errs);
    check("s1_cycles", cycles, 128);
    check("s1_pattern", pat_errs, 0);
    check("s1_done", done, 1);
    check("s1_pass", pass, 1);
    check("s1_err_cnt", err_cnt, 0);
    check("s1_fvalid", first_err_valid, 0);
    check("s1_vec", vec, 31);
    repeat (3) @(posedge clk);
    #1;
    check("s1_hold_done", done, 1);
    check("s1_hold_vec", vec, 31);

    // Errors at 13 and 20, run to completion.
    inj_en = 1'b1;
    do_run(1'b0, -1, cycles, pat_errs);
    check("s2_pass_cleared", snap_pass, 0);
    check("s2_done_cleared", snap_done, 0);
    check("s2_cycles", cycles, 128);
    check("s2_err_cnt", err_cnt, 2);
    check("s2_fvec", first_err_vec, 13);
    check("s2_fvalid", first_err_valid, 1);
    check("s2_pass", pass, 0);

    // Restart from DONE with an ignored start at vec=5.
    inj_en = 1'b0;
    do_run(1'b0, 21, cycles, pat_errs);
    check("s6_done_cleared", snap_done, 0);
    check("s6_err_cleared", snap_err, 0);
    check("s6_fvalid_cleared", snap_fv, 0);
    check("s6_cycles", cycles, 128);
    check("s6_pattern", pat_errs, 0);
    check("s6_pass", pass, 1);
    check("s6_vec", vec, 31);

    // Stop on first error at 13: 14 vectors x 4 cycles.
    inj_en = 1'b1;
    do_run(1'b1, -1, cycles, pat_errs);
    check("s3_cycles", cycles, 56);
    check("s3_done", done, 1);
    check("s3_vec", vec, 13);
    check("s3_err_cnt", err_cnt, 1);
    check("s3_fvec", first_err_vec, 13);
    check("s3_pass", pass, 0);

    // Async reset mid-SETTLE of vec=9 after an error at vec=3.
    inj_en = 1'b0; inj3_en = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (37) @(posedge clk);
    #1;
    check("s5_pre_vec", vec, 9);
    check("s5_pre_err", err_cnt, 1);
    check("s5_pre_fvec", first_err_vec, 3);
    #2 rst_n = 1'b0;
    #1;
    check("s5_vec", vec, 0);
    check("s5_busy", busy, 0);
    check("s5_err_cnt", err_cnt, 0);
    check("s5_fvalid", first_err_valid, 0);
    check("s5_fvec", first_err_vec, 0);
    check("s5_done", done, 0);
    @(negedge clk) rst_n = 1'b1;
    inj3_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("s5_idle_busy", busy, 0);
    check("s5_idle_strobe", cmp_strobe, 0);
    check("s5_idle_vec", vec, 0);

    // Saturating counter: every vector mismatches, ERR_W=2.
    @(negedge clk); start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0;
    cycles = 0;
    while (!done_s && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("s4_cycles", cycles, 128);
    check("s4_err_sat", err_cnt_s, 3);
    check("s4_fvec", first_err_vec_s, 0);
    check("s4_fvalid", first_err_valid_s, 1);
    check("s4_pass", pass_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
